// File: rtl/mult_seq_ctrl.sv
// Shift-and-add unsigned multiplier sequencer driving an external registered
// pipelined adder; operands and product move over valid/ready handshakes.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf,
  output logic                 busy,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_sum,
  input  logic                 add_cout
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned WCW = $clog2(ADD_LAT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
  localparam logic [WCW-1:0] WLAST    = WCW'(ADD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL  = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   product_q, product_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     unused_add_sum_hi;

  // Bits above the product width are always zero for a legal WIDTH.
  assign unused_add_sum_hi = add_sum >> PW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      ovf_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      ovf_q       <= ovf_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    ovf_d       = ovf_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = EVAL;
        end
        EVAL: begin
          if (cnt_q == CNT_LAST) begin
            product_d   = acc_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (mplier_q[0]) begin
            wcnt_d  = '0;
            state_d = WAIT;
          end else begin
            state_d = SHIFT;
          end
        end
        // Adder inputs have been stable since EVAL entry, so the sum at the
        // last WAIT edge is the exact acc + mcand.
        WAIT: begin
          if (wcnt_q == WLAST) begin
            acc_d   = add_sum[PW-1:0];
            ovf_d   = ovf_q | add_cout;
            state_d = SHIFT;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        SHIFT: begin
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          state_d  = EVAL;
        end
        DONE: if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign add_a     = 32'(acc_q);
  assign add_b     = 32'(mcand_q);
  assign add_cin   = 1'b0;

endmodule
